// File: rtl/serial_parallel.sv
// Serial-to-parallel deserialiser with comma-based word alignment.
// Hunts for COMMA, confirms ALIGN_COUNT spaced commas, then emits symbols.
module serial_parallel #(
    parameter int              WIDTH       = 10,
    parameter logic [WIDTH-1:0] COMMA      = 10'h0FA,
    parameter int              ALIGN_COUNT = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID,
    output logic             ACTIVE
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(ALIGN_COUNT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LOCK = CW'(ALIGN_COUNT);

    typedef enum logic [1:0] {
        HUNT,
        ALIGN,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [BW-1:0]    bit_inc;
    logic [CW-1:0]    comma_cnt;
    logic [CW-1:0]    comma_cnt_nxt;
    logic [CW-1:0]    comma_inc;
    logic [WIDTH-1:0] data_nxt;
    logic             valid_nxt;
    logic             active_nxt;
    logic             is_comma;
    logic             boundary;

    assign is_comma  = (shreg == COMMA);
    assign boundary  = (bit_cnt == '0);
    assign bit_inc   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    assign comma_inc = comma_cnt + 1'b1;

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        comma_cnt_nxt = comma_cnt;
        data_nxt      = DATA_OUT;
        valid_nxt     = 1'b0;
        active_nxt    = ACTIVE;
        unique case (state)
            HUNT: begin
                if (is_comma) begin
                    bit_cnt_nxt   = BW'(1);
                    comma_cnt_nxt = CW'(1);
                    if (CNT_LOCK <= CW'(1)) begin
                        state_nxt  = LOCKED;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt = ALIGN;
                    end
                end
            end
            ALIGN: begin
                bit_cnt_nxt = bit_inc;
                // Commas between boundaries are ignored here
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_nxt = comma_inc;
                        if (comma_inc == CNT_LOCK) begin
                            state_nxt  = LOCKED;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        comma_cnt_nxt = '0;
                        state_nxt     = HUNT;
                    end
                end
            end
            LOCKED: begin
                bit_cnt_nxt = bit_inc;
                if (boundary) begin
                    data_nxt  = shreg;
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= HUNT;
            shreg     <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            DATA_OUT  <= '0;
            VALID     <= 1'b0;
            ACTIVE    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= {shreg[WIDTH-2:0], DATA_IN};
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            DATA_OUT  <= data_nxt;
            VALID     <= valid_nxt;
            ACTIVE    <= active_nxt;
        end
    end

endmodule

// File: tb/tb_serial_parallel.sv
// Testbench for serial_parallel: scenario table plus random streams
// checked cycle by cycle against a stream-level alignment model.
module tb_serial_parallel;

    localparam logic [9:0] C  = 10'h0FA;
    localparam int         AC = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DATA_IN = 1'b0;
    logic [9:0] DATA_OUT;
    logic       VALID;
    logic       ACTIVE;

    serial_parallel #(.WIDTH(10), .COMMA(10'h0FA), .ALIGN_COUNT(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT),
        .VALID(VALID),
        .ACTIVE(ACTIVE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int              pre;
        int              nsym;
        logic [0:9][9:0] sym;
        int              nexp;
        logic [0:3][9:0] expv;
    } vec_t;

    vec_t       tbl [5];
    int         vectors = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         hist [$];
    bit         sb [$];
    logic [9:0] got [$];
    int         got_cyc [$];
    bit         m_valid [];
    bit         m_active [];
    logic [9:0] m_data [];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] win(int i);
        logic [9:0] w = '0;
        for (int t = 0; t < 10; t++) begin
            int idx = i - 9 + t;
            w = {w[8:0], (idx >= 0) ? hist[idx] : 1'b0};
        end
        return w;
    endfunction

    // Find the first run of AC commas at 10-bit spacing; a broken run
    // resumes the search one bit after the failed boundary.
    task automatic model();
        int n = hist.size();
        int lock_i = -1;
        int s = 0;
        bit done = 0;
        logic [9:0] d = '0;
        while (!done) begin
            int i = s;
            while (i <= n - 2 && win(i) != C) i++;
            if (i > n - 2) begin
                done = 1;
            end else begin
                int cnt = 1;
                int j = 1;
                bit stop = 0;
                while (!stop && cnt < AC) begin
                    int idx = i + 10 * j;
                    if (idx > n - 2) begin
                        stop = 1;
                        done = 1;
                    end else if (win(idx) == C) begin
                        cnt++;
                        j++;
                    end else begin
                        stop = 1;
                        s = idx + 1;
                    end
                end
                if (cnt == AC) begin
                    lock_i = i + 10 * (AC - 1);
                    done = 1;
                end
            end
        end
        m_valid  = new[n];
        m_active = new[n];
        m_data   = new[n];
        for (int k = 0; k < n; k++) begin
            m_valid[k]  = 0;
            m_active[k] = (lock_i >= 0) && (k >= lock_i + 1);
            if (lock_i >= 0 && k > lock_i + 1 && (k - lock_i - 1) % 10 == 0) begin
                m_valid[k] = 1;
                d = win(k - 1);
            end
            m_data[k] = d;
        end
    endtask

    task automatic add_sym(logic [9:0] s);
        for (int b = 9; b >= 0; b--) sb.push_back(s[b]);
    endtask

    task automatic add_rand_bits(int n);
        for (int b = 0; b < n; b++) sb.push_back(1'($urandom));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        DATA_IN = 1'($urandom);
        @(posedge CLK);
        #1;
        check("reset DATA_OUT", 32'(DATA_OUT), 32'h0);
        check("reset VALID", 32'(VALID), 32'h0);
        check("reset ACTIVE", 32'(ACTIVE), 32'h0);
        RESET = 1'b0;
        hist.delete();
        got.delete();
        got_cyc.delete();
    endtask

    task automatic run_stream();
        int base = hist.size();
        foreach (sb[i]) hist.push_back(sb[i]);
        sb.delete();
        model();
        for (int k = base; k < hist.size(); k++) begin
            DATA_IN = hist[k];
            @(posedge CLK);
            #1;
            cyc++;
            check($sformatf("VALID e%0d", k), 32'(VALID), 32'(m_valid[k]));
            check($sformatf("ACTIVE e%0d", k), 32'(ACTIVE), 32'(m_active[k]));
            check($sformatf("DATA_OUT e%0d", k), 32'(DATA_OUT), 32'(m_data[k]));
            if (VALID) begin
                got.push_back(DATA_OUT);
                got_cyc.push_back(cyc);
            end
        end
    endtask

    initial begin
        tbl[0] = '{pre: 0, nsym: 5,
                   sym: {C, C, C, C, 10'h2AA, 50'd0},
                   nexp: 1, expv: {10'h2AA, 30'd0}};
        tbl[1] = '{pre: 3, nsym: 6,
                   sym: {C, C, C, C, 10'h155, 10'h3C3, 40'd0},
                   nexp: 2, expv: {10'h155, 10'h3C3, 20'd0}};
        tbl[2] = '{pre: 0, nsym: 8,
                   sym: {C, C, 10'h000, C, C, C, C, 10'h1F0, 20'd0},
                   nexp: 1, expv: {10'h1F0, 30'd0}};
        tbl[3] = '{pre: 0, nsym: 7,
                   sym: {C, C, C, C, 10'h29F, 10'h133, 10'h155, 30'd0},
                   nexp: 3, expv: {10'h29F, 10'h133, 10'h155, 10'd0}};
        tbl[4] = '{pre: 5, nsym: 6,
                   sym: {C, C, C, C, C, 10'h3FF, 40'd0},
                   nexp: 2, expv: {C, 10'h3FF, 20'd0}};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            add_rand_bits(tbl[v].pre);
            for (int i = 0; i < tbl[v].nsym; i++) add_sym(tbl[v].sym[i]);
            sb.push_back(1'b0);
            sb.push_back(1'b0);
            run_stream();
            check($sformatf("t%0d valid count", v), 32'(got.size()), 32'(tbl[v].nexp));
            for (int i = 0; i < tbl[v].nexp && i < got.size(); i++)
                check($sformatf("t%0d sym%0d", v, i), 32'(got[i]), 32'(tbl[v].expv[i]));
            for (int i = 1; i < got_cyc.size(); i++)
                check($sformatf("t%0d spacing%0d", v, i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd10);
        end

        // Reset while locked, 5 bits into a symbol, then re-acquire
        do_reset();
        for (int i = 0; i < 4; i++) add_sym(C);
        add_sym(10'h2AA);
        add_sym(10'h3C3);
        for (int b = 9; b >= 5; b--) sb.push_back(1'b1);
        run_stream();
        check("mid valid count", 32'(got.size()), 32'd2);
        check("mid locked", 32'(ACTIVE), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) add_sym(C);
        add_sym(10'h2AA);
        for (int i = 0; i < 4; i++) add_sym(C);
        add_sym(10'h1F0);
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        run_stream();
        check("relock valid count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("relock sym", 32'(got[0]), 32'h1F0);

        // Random offsets and payloads
        for (int r = 0; r < 6; r++) begin
            do_reset();
            add_rand_bits($urandom_range(0, 9));
            for (int i = 0; i < 4; i++) add_sym(C);
            for (int i = 0; i < 20; i++) add_sym(10'($urandom));
            sb.push_back(1'b0);
            sb.push_back(1'b0);
            run_stream();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/serial_parallel.md
SERIAL_PARALLEL -- requirements
Module: serial_parallel

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, giving the symbol width in bits.
REQ-002 The module SHALL have parameter COMMA, default 10'h0FA, giving the K28.5 (RD-) alignment symbol.
REQ-003 The module SHALL have parameter ALIGN_COUNT, default 4, giving the number of consecutive aligned commas required for lock.
REQ-004 The module SHALL have port CLK, input, 1 bit, carrying the bit clock; all logic is on its rising edge.
REQ-005 The module SHALL have port RESET, input, 1 bit, which is a synchronous, active-high reset.
REQ-006 The module SHALL have port DATA_IN, input, 1 bit, carrying the serial stream, MSB (bit 9) of each symbol first, one bit per CLK.
REQ-007 The module SHALL have port DATA_OUT, output, WIDTH bits, carrying the recovered parallel symbol.
REQ-008 The module SHALL have port VALID, output, 1 bit, which pulses high for one cycle when DATA_OUT is updated.
REQ-009 The module SHALL have port ACTIVE, output, 1 bit, which is high while word alignment is locked.

Function
REQ-010 Shift register: each cycle, shreg SHALL be loaded with {shreg[WIDTH-2:0], DATA_IN}; the newest bit SHALL be in bit 0.
REQ-011 FSM SHALL have states HUNT, ALIGN and LOCKED, and SHALL enter HUNT on reset.
REQ-012 HUNT: every cycle, compare registered shreg to COMMA; on match SHALL set bit_cnt<=1, comma_cnt<=1 and go to ALIGN.
REQ-013 bit_cnt SHALL increment mod WIDTH every cycle outside HUNT; a cycle with bit_cnt==0 is a word boundary, exactly WIDTH cycles after the previous boundary or detection.
REQ-014 ALIGN, at boundary, shreg==COMMA: comma_cnt SHALL increment; on reaching ALIGN_COUNT, go to LOCKED, with ACTIVE<=1 at that edge.
REQ-015 ALIGN, at boundary, shreg!=COMMA: the FSM SHALL go to HUNT with comma_cnt<=0; a comma at a non-boundary offset in ALIGN SHALL be ignored.
REQ-016 ALIGN_COUNT SHALL count the initial detection, so the Nth comma SHALL be the ALIGN_COUNT-th consecutive comma at WIDTH spacing.
REQ-017 LOCKED, at each boundary: DATA_OUT<=shreg and VALID<=1 at that edge, so they are visible the cycle after the boundary; VALID SHALL be 0 on all other cycles.
REQ-018 The comma that completes lock SHALL NOT be output; the first VALID SHALL carry the next symbol.
REQ-019 LOCKED SHALL output commas like any other symbol; lock SHALL be held until reset, and misaligned commas in LOCKED SHALL be ignored.
REQ-020 DATA_OUT SHALL hold its last value between VALID pulses.
REQ-021 In HUNT/ALIGN, VALID SHALL be 0, ACTIVE SHALL be 0 and DATA_OUT SHALL hold.
REQ-022 Latency: the last bit of a symbol is sampled at edge e; VALID and DATA_OUT for that symbol SHALL be high/valid after edge e+1.

Reset
REQ-023 RESET high at a rising edge SHALL take priority over all other behaviour.
REQ-024 On reset, shreg, bit_cnt, comma_cnt, DATA_OUT, VALID and ACTIVE SHALL all be 0 and the FSM SHALL be in HUNT.
REQ-025 Reset asserted mid-symbol or while LOCKED SHALL drop ACTIVE at that edge and discard the partial symbol; re-acquisition SHALL restart from HUNT.
REQ-026 Shifting SHALL resume on the first edge with RESET low.

Verification
REQ-027 Lock: after reset, send 4x 10'h0FA back-to-back, then 10'h2AA -> ACTIVE rises the cycle after the 4th comma boundary; one VALID with DATA_OUT=10'h2AA; no VALID for any comma.
REQ-028 Offset: send 3 random bits, then 4x 0FA, then 10'h155, 10'h3C3 -> lock occurs regardless of offset; VALID pulses exactly 10 cycles apart carrying 155 then 3C3.
REQ-029 Broken alignment: send 2x 0FA, then 10'h000, then 4x 0FA, then 10'h1F0 -> FSM returns to HUNT after 000 and ACTIVE stays 0 until the later 4 commas; then 1F0 is output.
REQ-030 Reset mid-run: while LOCKED, pulse RESET for 1 cycle at bit 5 of a symbol -> same cycle edge gives DATA_OUT=0, VALID=0, ACTIVE=0; re-lock requires 4 fresh commas.
REQ-031 Loopback: chain parallel_serial to serial_parallel; drive 4x 0FA followed by 20 random symbols -> output sequence equals input sequence, with constant latency and no gaps.
REQ-032 Lock hold: while LOCKED, insert a 0FA pattern at a non-boundary offset -> ACTIVE stays 1 and the boundary timing is unchanged.
